hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_pkg.sv | 19 +
 rtl/hilo_muldiv_unit_iter.sv | 33 +++
 rtl/hilo_muldiv_unit.sv | 94 +++++++++
 tb/tb_hilo_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and default operand width.
package hilo_muldiv_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   typedef enum logic {
      OP_MULTU = 1'b0,
      OP_DIVU  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_iter.sv
// One combinational iteration of the shared accumulator: shift-add for MULTU,
// compare-subtract-shift (restoring) for DIVU.
module muldiv_iter
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH = hilo_muldiv_pkg::WIDTH
) (
   input  op_e                  op,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   upper;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // MULTU: acc = {partial product, remaining multiplier bits}
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      // DIVU: acc = {remainder, dividend/quotient}; upper is the remainder after the left shift
      upper = acc[2*WIDTH-1:WIDTH-1];
      diff  = upper[WIDTH-1:0] - operand;
      if (op == OP_MULTU) begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end else if (upper >= {1'b0, operand}) begin
         acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit with HI/LO result registers; one
// iteration per clock, results committed only on the final iteration.
module hilo_muldiv_unit
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH = hilo_muldiv_pkg::WIDTH,
   parameter int CNT_W = hilo_muldiv_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic             rd_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dataOut
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state, state_next;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   operand;
   op_e                op_q;
   logic [WIDTH-1:0]   hi, lo;
   logic               accept;
   logic               last;

   assign accept = (state == IDLE) && start;
   assign last   = (state == CALC) && (count == LAST_CNT);

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .op       (op_q),
      .acc      (acc),
      .operand  (operand),
      .acc_next (acc_next)
   );

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (count == LAST_CNT) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            count <= '0;
         end else if (state == CALC) begin
            count <= count + 1'b1;
         end
         if (last) begin
            hi <= acc_next[2*WIDTH-1:WIDTH];
            lo <= acc_next[WIDTH-1:0];
         end
      end
   end

   // Operand latch and accumulator carry no reset; they are only read in CALC.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= op_e'(op);
         operand <= op ? dataB : dataA;
         acc     <= {{WIDTH{1'b0}}, (op ? dataA : dataB)};
      end else if (state == CALC) begin
         acc <= acc_next;
      end
   end

   assign dataOut = rd_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: latency, results, stale reads,
// ignored starts, mid-operation reset and back-to-back operation.
module tb_hilo_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        rd_sel;
   logic        busy;
   logic        done;
   logic [31:0] dataOut;

   int n_vec;
   int n_err;

   hilo_muldiv_unit dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .dataA   (dataA),
      .dataB   (dataB),
      .rd_sel  (rd_sel),
      .busy    (busy),
      .done    (done),
      .dataOut (dataOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      rd_sel = 1'b1;
      #1 h = dataOut;
      rd_sel = 1'b0;
      #1 l = dataOut;
   endtask

   // Issues one operation and waits (bounded) for done; lat counts cycles
   // from the cycle start is presented to the cycle done is seen.
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      op = o; dataA = a; dataB = b; start = 1'b1;
      step();
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] h, l;
      reset = 1'b1;
      step();
      reset = 1'b0;
      read_hilo(h, l);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_vec++;
      if (h !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 00000000", h); end
      n_vec++;
      if (l !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 00000000", l); end
   endtask

   task automatic test_mul_max();
      int lat, bcnt;
      logic [31:0] h, l;
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (lat !== 33) begin n_err++; $display("FAIL mul_max_latency: got %0d want 33", lat); end
      n_vec++;
      if (h !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mul_max_hi: got %h want fffffffe", h); end
      n_vec++;
      if (l !== 32'h0000_0001) begin n_err++; $display("FAIL mul_max_lo: got %h want 00000001", l); end
      step();
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_single_cycle: got %b want 0", done); end
   endtask

   task automatic test_div_basic();
      int lat, bcnt;
      logic [31:0] h, l;
      run_op(1'b1, 32'd100, 32'd7, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (bcnt !== 32) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 32", bcnt); end
      n_vec++;
      if (l !== 32'd14) begin n_err++; $display("FAIL div_quot: got %0d want 14", l); end
      n_vec++;
      if (h !== 32'd2) begin n_err++; $display("FAIL div_rem: got %0d want 2", h); end
      step();
   endtask

   task automatic test_div_zero();
      int lat, bcnt;
      logic [31:0] h, l;
      run_op(1'b1, 32'h1234_5678, 32'h0, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (lat !== 33) begin n_err++; $display("FAIL div0_latency: got %0d want 33", lat); end
      n_vec++;
      if (l !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_quot: got %h want ffffffff", l); end
      n_vec++;
      if (h !== 32'h1234_5678) begin n_err++; $display("FAIL div0_rem: got %h want 12345678", h); end
      step();
   endtask

   task automatic test_boundaries();
      int lat, bcnt;
      logic [31:0] h, l;
      run_op(1'b1, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (l !== 32'hFFFF_FFFF || h !== 32'h0) begin
         n_err++; $display("FAIL div_by_one: got hi=%h lo=%h want hi=00000000 lo=ffffffff", h, l);
      end
      step();
      run_op(1'b1, 32'd5, 32'd9, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (l !== 32'd0 || h !== 32'd5) begin
         n_err++; $display("FAIL div_small_dividend: got hi=%0d lo=%0d want hi=5 lo=0", h, l);
      end
      step();
      run_op(1'b0, 32'h0001_0000, 32'h0001_0000, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (h !== 32'd1 || l !== 32'd0) begin
         n_err++; $display("FAIL mul_carry_into_hi: got hi=%h lo=%h want hi=00000001 lo=00000000", h, l);
      end
      step();
   endtask

   task automatic test_stale_and_ignored_start();
      int lat, bcnt;
      int stale_err;
      logic [31:0] h, l;
      logic [31:0] want;
      run_op(1'b1, 32'd47, 32'd7, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (h !== 32'd5 || l !== 32'd6) begin
         n_err++; $display("FAIL prior_hilo: got hi=%0d lo=%0d want hi=5 lo=6", h, l);
      end
      step();
      op = 1'b0; dataA = 32'd3; dataB = 32'd4; start = 1'b1;
      step();
      start = 1'b0;
      lat = 1;
      stale_err = 0;
      while (!done && lat < 100) begin
         if (lat == 9) begin start = 1'b1; op = 1'b1; dataA = 32'd77; dataB = 32'd1; end
         if (lat == 10) begin start = 1'b0; dataA = 32'd1000; end
         rd_sel = lat[0];
         want = lat[0] ? 32'd5 : 32'd6;
         #1;
         n_vec++;
         if (dataOut !== want) begin
            n_err++; stale_err++;
            if (stale_err < 4) $display("FAIL stale_read_cycle%0d: got %0d want %0d", lat, dataOut, want);
         end
         step();
         lat++;
      end
      read_hilo(h, l);
      n_vec++;
      if (lat !== 33) begin n_err++; $display("FAIL ignored_start_latency: got %0d want 33", lat); end
      n_vec++;
      if (h !== 32'd0 || l !== 32'd12) begin
         n_err++; $display("FAIL mul_3x4: got hi=%0d lo=%0d want hi=0 lo=12", h, l);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL no_queued_op: got busy=%b done=%b want 0/0", busy, done);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat, bcnt;
      int done_seen;
      logic [31:0] h, l;
      op = 1'b0; dataA = 32'd7; dataB = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      read_hilo(h, l);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_vec++;
      if (h !== 32'd0 || l !== 32'd0) begin
         n_err++; $display("FAIL abort_hilo: got hi=%h lo=%h want 0/0", h, l);
      end
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_seen++;
         step();
      end
      n_vec++;
      if (done_seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
      run_op(1'b0, 32'd7, 32'd9, lat, bcnt);
      read_hilo(h, l);
      n_vec++;
      if (lat !== 33 || h !== 32'd0 || l !== 32'd63) begin
         n_err++; $display("FAIL after_abort_mul: got lat=%0d hi=%0d lo=%0d want lat=33 hi=0 lo=63", lat, h, l);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int first_done, second_done, n_done;
      int lat;
      logic [31:0] h, l;
      op = 1'b1; dataA = 32'd9; dataB = 32'd3; start = 1'b1;
      first_done = -1; second_done = -1; n_done = 0;
      for (int i = 1; i <= 80; i++) begin
         step();
         if (done) begin
            n_done++;
            if (n_done == 1) first_done = i;
            if (n_done == 2) second_done = i;
            read_hilo(h, l);
            n_vec++;
            if (h !== 32'd0 || l !== 32'd3) begin
               n_err++; $display("FAIL b2b_result%0d: got hi=%0d lo=%0d want hi=0 lo=3", n_done, h, l);
            end
         end
      end
      start = 1'b0;
      n_vec++;
      if (n_done !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", n_done); end
      n_vec++;
      if (first_done !== 33) begin n_err++; $display("FAIL b2b_first: got %0d want 33", first_done); end
      n_vec++;
      if (second_done - first_done !== 34) begin
         n_err++; $display("FAIL b2b_spacing: got %0d want 34", second_done - first_done);
      end
      lat = 0;
      while (!done && lat < 100) begin step(); lat++; end
      n_vec++;
      if (done !== 1'b1) begin n_err++; $display("FAIL b2b_third_done: got %b want 1", done); end
      step();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b0; start = 1'b0; op = 1'b0; rd_sel = 1'b0;
      dataA = '0; dataB = '0;
      step();
      test_reset();
      test_mul_max();
      test_div_basic();
      test_div_zero();
      test_boundaries();
      test_stale_and_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
